mux8x1_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one 8:1 single-bit mux path among 8 requesters.

---
 rtl/mux8x1_rr_sched.sv | 129 ++++++++++++
 tb/tb_mux8x1_rr_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux8x1_rr_sched.sv
// Round-robin scheduler owning the select of a shared 8:1 single-bit mux.
// Grants one requester at a time for at most MAX_BURST cycles and registers the muxed bit.
module mux8x1_rr_sched #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] in,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       out,
  output logic       out_valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] last_q, last_d;
  logic       out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] pick_s;
  logic       release_s;

  // First requester at or after start, wrapping 7->0.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Next-state: arbitration, burst counting and data transfer.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pick_s      = 3'd0;
    release_s   = 1'b0;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (|req) begin
          pick_s  = pick(req, last_q + 3'd1);
          sel_d   = pick_s;
          gnt_d   = 8'd1 << pick_s;
          cnt_d   = 4'd1;
          state_d = GRANT;
        end else begin
          gnt_d = 8'd0;
        end
      end
      GRANT: begin
        if (req[sel_q]) begin
          out_d       = in[sel_q];
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
        // A dropped request and an exhausted burst on the same cycle are one release.
        release_s = !req[sel_q] || (cnt_q == MAX_CNT);
        if (release_s) begin
          last_d = sel_q;
          if (|req) begin
            pick_s = pick(req, sel_q + 3'd1);
            sel_d  = pick_s;
            gnt_d  = 8'd1 << pick_s;
            cnt_d  = 4'd1;
          end else begin
            gnt_d   = 8'd0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register; last resets to 7 so the first search starts at source 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      gnt_q       <= 8'd0;
      cnt_q       <= 4'd0;
      last_q      <= 3'd7;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign busy      = (state_q == GRANT);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux8x1_rr_sched.sv
// Self-checking bench for mux8x1_rr_sched: hand-derived vector table for the corner cases,
// plus a cycle model feeding a scoreboard for round-robin, single-requester and random traffic.
module tb_mux8x1_rr_sched;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] din;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       out;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       out;
    logic       ov;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       out;
    logic       ov;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  // Reference model state (outputs after the most recent edge).
  logic       m_busy, m_out, m_ov;
  logic [2:0] m_sel, m_last;
  int         m_cnt;

  mux8x1_rr_sched #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .in(din), .sel(sel), .gnt(gnt),
    .busy(busy), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] mpick(input logic [7:0] r, input logic [2:0] start);
    logic [15:0] rot;
    rot = {r, r} >> start;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) mpick = 3'((int'(start) + k) % 8);
    end
  endfunction

  task automatic model_step(input logic r, input logic [7:0] rq, input logic [7:0] d,
                            input string name, output exp_t e);
    logic       rel;
    logic [2:0] owner;
    if (r) begin
      m_busy = 1'b0; m_sel = 3'd0; m_out = 1'b0; m_ov = 1'b0; m_cnt = 0; m_last = 3'd7;
    end else if (!m_busy) begin
      m_ov = 1'b0;
      if (rq != 8'd0) begin
        m_sel = mpick(rq, m_last + 3'd1); m_cnt = 1; m_busy = 1'b1;
      end
    end else begin
      owner = m_sel;
      m_ov  = rq[owner];
      if (rq[owner]) m_out = d[owner];
      rel = !rq[owner] || (m_cnt == MAXB);
      if (rel) begin
        m_last = owner;
        if (rq != 8'd0) begin
          m_sel = mpick(rq, owner + 3'd1); m_cnt = 1;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_cnt++;
      end
    end
    e.name = name; e.sel = m_sel; e.gnt = m_busy ? (8'd1 << m_sel) : 8'd0;
    e.busy = m_busy; e.out = m_out; e.ov = m_ov;
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if ({sel, gnt, busy, out, out_valid} !== {e.sel, e.gnt, e.busy, e.out, e.ov}) begin
      failures++;
      $display("FAIL %s @%0t: got sel=%0d gnt=%h busy=%b out=%b out_valid=%b, want sel=%0d gnt=%h busy=%b out=%b out_valid=%b",
               e.name, $time, sel, gnt, busy, out, out_valid, e.sel, e.gnt, e.busy, e.out, e.ov);
    end
  endtask

  task automatic apply(input logic r, input logic [7:0] rq, input logic [7:0] d, input exp_t e);
    rst = r; req = rq; din = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic model_apply(input logic r, input logic [7:0] rq, input logic [7:0] d, input string name);
    exp_t e;
    model_step(r, rq, d, name, e);
    apply(r, rq, d, e);
  endtask

  task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] d, input logic [2:0] s,
                     input logic [7:0] g, input logic b, input logic o, input logic v);
    vec_t t;
    t.rst = r; t.req = rq; t.din = d; t.sel = s; t.gnt = g; t.busy = b; t.out = o; t.ov = v;
    tbl.push_back(t);
  endtask

  initial begin
    exp_t e, dummy;
    rst = 1'b1; req = 8'd0; din = 8'd0;
    // reset with all requesting, then first grant and drop to idle
    add(1, 8'hFF, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 8'hFF, 8'h00, 0, 8'h01, 1, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    // early release of owner 3 hands over to 5 with one invalid cycle
    add(0, 8'h28, 8'h08, 3, 8'h08, 1, 0, 0);
    add(0, 8'h28, 8'h08, 3, 8'h08, 1, 1, 1);
    add(0, 8'h28, 8'h08, 3, 8'h08, 1, 1, 1);
    add(0, 8'h20, 8'h08, 5, 8'h20, 1, 1, 0);
    add(0, 8'h20, 8'h00, 5, 8'h20, 1, 0, 1);
    add(0, 8'h00, 8'h00, 5, 8'h00, 0, 0, 0);
    // last=6, then req {6,0}: search wraps 7->0, full burst on 0, then 6
    add(0, 8'h40, 8'h00, 6, 8'h40, 1, 0, 0);
    add(0, 8'h00, 8'h00, 6, 8'h00, 0, 0, 0);
    add(0, 8'h41, 8'h41, 0, 8'h01, 1, 0, 0);
    add(0, 8'h41, 8'h41, 0, 8'h01, 1, 1, 1);
    add(0, 8'h41, 8'h41, 0, 8'h01, 1, 1, 1);
    add(0, 8'h41, 8'h41, 0, 8'h01, 1, 1, 1);
    add(0, 8'h41, 8'h41, 6, 8'h40, 1, 1, 1);
    add(0, 8'h41, 8'h41, 6, 8'h40, 1, 1, 1);
    add(0, 8'h00, 8'h41, 6, 8'h00, 0, 1, 0);
    // reset mid-burst on owner 4, then restart from source 0
    add(0, 8'h10, 8'h10, 4, 8'h10, 1, 1, 0);
    add(0, 8'h10, 8'h10, 4, 8'h10, 1, 1, 1);
    add(1, 8'h10, 8'h10, 0, 8'h00, 0, 0, 0);
    add(0, 8'hFF, 8'h00, 0, 8'h01, 1, 0, 0);
    add(0, 8'hFF, 8'h00, 0, 8'h01, 1, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      model_step(tbl[i].rst, tbl[i].req, tbl[i].din, "table", dummy);
      e.name = $sformatf("table[%0d]", i);
      e.sel = tbl[i].sel; e.gnt = tbl[i].gnt; e.busy = tbl[i].busy;
      e.out = tbl[i].out; e.ov = tbl[i].ov;
      apply(tbl[i].rst, tbl[i].req, tbl[i].din, e);
    end

    // single requester keeps being regranted with no drop
    model_apply(1'b1, 8'h00, 8'h00, "single_rst");
    for (int i = 0; i < 10; i++) model_apply(1'b0, 8'h04, 8'h04, "single");

    // full round robin: owners 0..7,0 each for MAX_BURST cycles
    model_apply(1'b1, 8'h00, 8'h00, "rr_rst");
    for (int i = 0; i < 8 * MAXB + 2; i++) model_apply(1'b0, 8'hFF, 8'h66, "round_robin");

    // random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      logic       r;
      logic [7:0] rq;
      r  = ($urandom_range(0, 31) == 0);
      rq = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      model_apply(r, rq, 8'($urandom), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
